// File: rtl/uart_debug_responder.sv
// ---------------------------------------------------------------------------
// uart_debug_responder
//
// Host-driven debug responder on a UART byte interface. The host sends short
// commands and this block answers each one with a single byte:
//   'R' AH AL     -> reply mem[{AH,AL}]
//   'W' AH AL D   -> mem[{AH,AL}] = D, reply 'K'
//   anything else -> reply '?' (no halt, no bus access)
// For a read or write the CPU is halted, and after a settle time this block
// drives the memory bus as a second initiator. The CPU is released once the
// reply byte has been transmitted.
//
// Build option (macro DBG_CHECKSUM_EN):
//   defined   : each R/W command carries a trailing XOR checksum byte. A bad
//               checksum is answered with '!' without halting or accessing
//               the bus.
//   undefined : the command ends at AL (R) or D (W).
//
// Parameters:
//   TIMEOUT_CYCLES : inter-byte timeout while collecting a command
//   RD_LATENCY     : cycles from mem_addr valid to mem_di valid
//   HALT_SETTLE    : cycles cpu_halt is high before the bus is driven
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   rx_data, rx_done    received byte and its one-cycle valid strobe
//   tx_data, tx_wr      reply byte and one-cycle transmit start
//   tx_done             one-cycle strobe: transmitter finished the byte
//   cpu_halt            CPU frozen, bus owned by this block
//   mem_addr, mem_do    bus address and write data
//   mem_di              bus read data
//   mem_we              one-cycle bus write enable
//   busy                high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module uart_debug_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned HALT_SETTLE    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_done,
  output logic        cpu_halt,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_do,
  input  logic [7:0]  mem_di,
  output logic        mem_we,
  output logic        busy
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      SETTLE_LAST = (HALT_SETTLE > 1) ? 8'(HALT_SETTLE - 1) : 8'd0;
  localparam logic [7:0]      RD_LAST     = 8'(RD_LATENCY);

  localparam logic [7:0] OP_RD    = 8'h52;  // 'R'
  localparam logic [7:0] OP_WR    = 8'h57;  // 'W'
  localparam logic [7:0] RSP_ACK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_BAD  = 8'h3F;  // '?'
`ifdef DBG_CHECKSUM_EN
  localparam logic [7:0] RSP_CSUM = 8'h21;  // '!'
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA,
`ifdef DBG_CHECKSUM_EN
    S_CSUM,
`endif
    S_HALT_WAIT,
    S_MEM_RD,
    S_MEM_WR,
    S_TX,
    S_TX_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic            is_wr_q, is_wr_d;
  logic [15:0]     addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      wait_cnt_q, wait_cnt_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            cpu_halt_q, cpu_halt_d;
  logic [15:0]     mem_addr_q, mem_addr_d;
  logic [7:0]      mem_do_q, mem_do_d;
`ifdef DBG_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif
  logic            collecting;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      to_cnt_q   <= '0;
      wait_cnt_q <= '0;
      tx_data_q  <= '0;
      cpu_halt_q <= 1'b0;
      mem_addr_q <= '0;
      mem_do_q   <= '0;
`ifdef DBG_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      to_cnt_q   <= to_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      tx_data_q  <= tx_data_d;
      cpu_halt_q <= cpu_halt_d;
      mem_addr_q <= mem_addr_d;
      mem_do_q   <= mem_do_d;
`ifdef DBG_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    to_cnt_d   = '0;
    wait_cnt_d = wait_cnt_q;
    tx_data_d  = tx_data_q;
    cpu_halt_d = cpu_halt_q;
    mem_addr_d = mem_addr_q;
    mem_do_d   = mem_do_q;
`ifdef DBG_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    collecting = (state_q == S_ADDR_HI) || (state_q == S_ADDR_LO) || (state_q == S_DATA);
`ifdef DBG_CHECKSUM_EN
    if (state_q == S_CSUM) collecting = 1'b1;
`endif

    // Inter-byte timeout. A byte arriving on the expiry cycle wins because
    // the byte-state branches below only act on rx_done and override this.
    if (collecting && !rx_done) begin
      if (to_cnt_q == TO_LAST) state_d = S_IDLE;
      else                     to_cnt_d = to_cnt_q + TO_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (rx_done) begin
          if (rx_data == OP_RD || rx_data == OP_WR) begin
            is_wr_d = (rx_data == OP_WR);
`ifdef DBG_CHECKSUM_EN
            csum_d  = rx_data;
`endif
            state_d = S_ADDR_HI;
          end else begin
            tx_data_d = RSP_BAD;
            state_d   = S_TX;
          end
        end
      end
      S_ADDR_HI: begin
        if (rx_done) begin
          addr_d[15:8] = rx_data;
`ifdef DBG_CHECKSUM_EN
          csum_d       = csum_q ^ rx_data;
`endif
          state_d      = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (rx_done) begin
          addr_d[7:0] = rx_data;
`ifdef DBG_CHECKSUM_EN
          csum_d      = csum_q ^ rx_data;
`endif
          if (is_wr_q) begin
            state_d = S_DATA;
          end else begin
`ifdef DBG_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d    = S_HALT_WAIT;
            cpu_halt_d = 1'b1;
            wait_cnt_d = '0;
`endif
          end
        end
      end
      S_DATA: begin
        if (rx_done) begin
          data_d = rx_data;
`ifdef DBG_CHECKSUM_EN
          csum_d  = csum_q ^ rx_data;
          state_d = S_CSUM;
`else
          state_d    = S_HALT_WAIT;
          cpu_halt_d = 1'b1;
          wait_cnt_d = '0;
`endif
        end
      end
`ifdef DBG_CHECKSUM_EN
      S_CSUM: begin
        if (rx_done) begin
          if (rx_data == csum_q) begin
            state_d    = S_HALT_WAIT;
            cpu_halt_d = 1'b1;
            wait_cnt_d = '0;
          end else begin
            tx_data_d = RSP_CSUM;
            state_d   = S_TX;
          end
        end
      end
`endif
      S_HALT_WAIT: begin
        // Bus outputs only change once halt has been stable long enough for
        // the CPU to have let go of the bus.
        if (wait_cnt_q == SETTLE_LAST) begin
          wait_cnt_d = '0;
          mem_addr_d = addr_q;
          if (is_wr_q) begin
            mem_do_d = data_q;
            state_d  = S_MEM_WR;
          end else begin
            state_d  = S_MEM_RD;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_MEM_RD: begin
        if (wait_cnt_q == RD_LAST) begin
          tx_data_d = mem_di;
          state_d   = S_TX;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_MEM_WR: begin
        tx_data_d = RSP_ACK;
        state_d   = S_TX;
      end
      S_TX: begin
        state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (tx_done) begin
          cpu_halt_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes decode straight from the state register, so each lasts exactly
  // the one cycle spent in its state.
  assign tx_wr    = (state_q == S_TX);
  assign mem_we   = (state_q == S_MEM_WR);
  assign busy     = (state_q != S_IDLE);
  assign tx_data  = tx_data_q;
  assign cpu_halt = cpu_halt_q;
  assign mem_addr = mem_addr_q;
  assign mem_do   = mem_do_q;

endmodule
